// File: rtl/mem_arbiter.sv
// Arbiter for the unified single-ported memory: data port has priority, a streak counter forces fetch progress.
// Optional alignment check enabled by defining MEM_ARB_ALIGN_CHK_EN.
//
// state  | meaning
// IDLE   | no transaction; pick a winner from the pending requests
// I_BUSY | fetch transaction outstanding, waiting for mem_rdy
// D_BUSY | data transaction outstanding, waiting for mem_rdy
// ERR    | one-cycle misaligned-access response (only with MEM_ARB_ALIGN_CHK_EN)
module mem_arbiter #(
  parameter int MAX_D_STREAK = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [15:0] i_addr,
  output logic        i_done,
  output logic [15:0] i_rdata,
  output logic        i_stall,
  input  logic        d_rd,
  input  logic        d_wr,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic        d_done,
  output logic [15:0] d_rdata,
  output logic        d_stall,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic        mem_rdy,
  input  logic [15:0] mem_rdata,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY, ERR} state_t;

  localparam logic [3:0] MAX_S = 4'(MAX_D_STREAK);

  state_t      state_q, state_d;
  logic [3:0]  streak_q, streak_d;
  logic        mem_en_q, mem_en_d;
  logic        mem_wr_q, mem_wr_d;
  logic [15:0] mem_addr_q, mem_addr_d;
  logic [15:0] mem_wdata_q, mem_wdata_d;
  logic        err_data_q, err_data_d;

  logic d_req, d_win, i_win, bad_addr;
  logic i_fin, d_fin, i_err, d_err;

  always_comb begin
    d_req = d_rd | d_wr;
    d_win = d_req && !(i_req && (streak_q == MAX_S));
    i_win = !d_win && i_req;
`ifdef MEM_ARB_ALIGN_CHK_EN
    bad_addr = d_win ? d_addr[0] : i_addr[0];
`else
    bad_addr = 1'b0;
`endif
  end

  always_comb begin
    state_d     = state_q;
    streak_d    = streak_q;
    mem_en_d    = 1'b0;
    mem_wr_d    = mem_wr_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    err_data_d  = err_data_q;
    case (state_q)
      IDLE: begin
        if (d_win || i_win) begin
          if (d_win && i_req)
            streak_d = (streak_q == MAX_S) ? streak_q : streak_q + 4'd1;
          else
            streak_d = 4'd0;
          if (bad_addr) begin
            // Misaligned access is answered locally; the backend never sees it.
            state_d    = ERR;
            err_data_d = d_win;
          end else begin
            state_d    = d_win ? D_BUSY : I_BUSY;
            mem_en_d   = 1'b1;
            mem_wr_d   = d_win & d_wr;
            mem_addr_d = d_win ? d_addr : i_addr;
            if (d_win)
              mem_wdata_d = d_wdata;
          end
        end
      end
      I_BUSY, D_BUSY: begin
        if (mem_rdy)
          state_d = IDLE;
      end
      ERR: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      streak_q    <= 4'd0;
      mem_en_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= 16'h0000;
      mem_wdata_q <= 16'h0000;
      err_data_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      streak_q    <= streak_d;
      mem_en_q    <= mem_en_d;
      mem_wr_q    <= mem_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      err_data_q  <= err_data_d;
    end
  end

  always_comb begin
    i_fin = (state_q == I_BUSY) && mem_rdy;
    d_fin = (state_q == D_BUSY) && mem_rdy;
    i_err = (state_q == ERR) && !err_data_q;
    d_err = (state_q == ERR) && err_data_q;
  end

  assign i_done    = i_fin | i_err;
  assign d_done    = d_fin | d_err;
  assign i_rdata   = i_fin ? mem_rdata : 16'h0000;
  assign d_rdata   = d_fin ? mem_rdata : 16'h0000;
  assign i_stall   = i_req & ~i_done;
  assign d_stall   = d_req & ~d_done;
  assign mem_en    = mem_en_q;
  assign mem_wr    = mem_wr_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
`ifdef MEM_ARB_ALIGN_CHK_EN
  assign err = (state_q == ERR);
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter; inputs change 1ns after posedge, outputs sampled on negedge.
module tb_mem_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, d_rd, d_wr, mem_rdy;
  logic [15:0] i_addr, d_addr, d_wdata, mem_rdata;
  logic        i_done, i_stall, d_done, d_stall, mem_en, mem_wr, err;
  logic [15:0] i_rdata, d_rdata, mem_addr, mem_wdata;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.MAX_D_STREAK(4)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata), .i_stall(i_stall),
    .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(d_done), .d_rdata(d_rdata), .d_stall(d_stall),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdy(mem_rdy), .mem_rdata(mem_rdata), .err(err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; i_req = 1'b0; d_rd = 1'b0; d_wr = 1'b0; mem_rdy = 1'b0;
    i_addr = 16'h0; d_addr = 16'h0; d_wdata = 16'h0; mem_rdata = 16'h0;
    step(); step();
    smp();
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_wr", mem_wr, 0);
    chk("rst_done", {i_done, d_done, err}, 0);
    chk("rst_addr", mem_addr, 16'h0000);
    chk("rst_wdata", mem_wdata, 16'h0000);
    chk("rst_rdata", {i_rdata, d_rdata}, 0);
    chk("rst_stall", {i_stall, d_stall}, 0);
    step(); rst = 1'b0;
    step();

    // single fetch, latency 2
    i_req = 1'b1; i_addr = 16'h0010;
    smp(); chk("f_c0_stall", i_stall, 1); chk("f_c0_en", mem_en, 0);
    step(); smp();
    chk("f_c1_en", mem_en, 1); chk("f_c1_addr", mem_addr, 16'h0010);
    chk("f_c1_wr", mem_wr, 0); chk("f_c1_stall", i_stall, 1);
    step(); smp();
    chk("f_c2_en", mem_en, 0); chk("f_c2_done", i_done, 0); chk("f_c2_stall", i_stall, 1);
    step(); mem_rdy = 1'b1; mem_rdata = 16'hC001;
    smp();
    chk("f_c3_done", i_done, 1); chk("f_c3_rdata", i_rdata, 16'hC001);
    chk("f_c3_stall", i_stall, 0); chk("f_c3_ddone", d_done, 0);
    step(); mem_rdy = 1'b0; i_req = 1'b0;
    smp(); chk("f_c4_done", i_done, 0); chk("f_c4_rdata", i_rdata, 16'h0000);
    step();

    // simultaneous fetch and data write: data first
    i_req = 1'b1; i_addr = 16'h0040; d_wr = 1'b1; d_addr = 16'h0020; d_wdata = 16'hBEEF;
    step(); smp();
    chk("s_c1_en", mem_en, 1); chk("s_c1_addr", mem_addr, 16'h0020);
    chk("s_c1_wr", mem_wr, 1); chk("s_c1_wdata", mem_wdata, 16'hBEEF);
    step();
    step(); mem_rdy = 1'b1; mem_rdata = 16'h7777;
    smp();
    chk("s_c3_ddone", d_done, 1); chk("s_c3_idone", i_done, 0);
    chk("s_c3_drdata", d_rdata, 16'h7777); chk("s_c3_dstall", d_stall, 0);
    step(); mem_rdy = 1'b0; d_wr = 1'b0;
    smp(); chk("s_c4_en", mem_en, 0);
    step(); smp();
    chk("s_c5_en", mem_en, 1); chk("s_c5_addr", mem_addr, 16'h0040); chk("s_c5_wr", mem_wr, 0);
    step();
    step(); mem_rdy = 1'b1; mem_rdata = 16'h1234;
    smp(); chk("s_c7_idone", i_done, 1); chk("s_c7_irdata", i_rdata, 16'h1234);
    step(); mem_rdy = 1'b0; i_req = 1'b0;
    step();

    // starvation guard: both held, expect D D D D I D D D D I
    i_req = 1'b1; i_addr = 16'h0100; d_rd = 1'b1; d_addr = 16'h0200;
    for (int g = 0; g < 10; g++) begin
      int waited;
      logic seen;
      waited = 0; seen = 1'b0;
      while (!seen && waited < 6) begin
        smp();
        if (mem_en) seen = 1'b1;
        else begin step(); waited++; end
      end
      chk($sformatf("starve_grant%0d_seen", g), seen, 1);
      chk($sformatf("starve_grant%0d_addr", g), mem_addr, (g % 5 == 4) ? 16'h0100 : 16'h0200);
      step();
      step(); mem_rdy = 1'b1; mem_rdata = 16'h0F0F;
      step(); mem_rdy = 1'b0;
    end
    i_req = 1'b0; d_rd = 1'b0;
    step(); step(); step(); step();

    // flush: fetch dropped mid-transaction
    i_req = 1'b1; i_addr = 16'h0050;
    step(); smp(); chk("fl_c1_en", mem_en, 1);
    step(); i_req = 1'b0;
    smp(); chk("fl_c2_stall", i_stall, 0);
    step(); mem_rdy = 1'b1; mem_rdata = 16'h2222;
    smp(); chk("fl_c3_done", i_done, 1);
    step(); mem_rdy = 1'b0; d_rd = 1'b1; d_addr = 16'h0060;
    step(); smp();
    chk("fl_c5_en", mem_en, 1); chk("fl_c5_addr", mem_addr, 16'h0060);
    step();
    step(); mem_rdy = 1'b1; mem_rdata = 16'hABCD;
    smp(); chk("fl_c7_ddone", d_done, 1); chk("fl_c7_drdata", d_rdata, 16'hABCD);
    step(); mem_rdy = 1'b0; d_rd = 1'b0;
    step();

    // reset mid-transaction
    i_req = 1'b1; i_addr = 16'h0070;
    step(); smp(); chk("r_c1_en", mem_en, 1); chk("r_c1_addr", mem_addr, 16'h0070);
    step(); rst = 1'b1;
    step(); rst = 1'b0; i_req = 1'b0;
    smp();
    chk("r_c3_en", mem_en, 0); chk("r_c3_addr", mem_addr, 16'h0000);
    chk("r_c3_wr", mem_wr, 0); chk("r_c3_done", {i_done, d_done, err}, 0);
    step(); mem_rdy = 1'b1; mem_rdata = 16'h9999;
    smp(); chk("r_c4_nodone", {i_done, d_done}, 0); chk("r_c4_rdata", i_rdata, 16'h0000);
    step(); mem_rdy = 1'b0;
    step();

    // misaligned data read
    d_rd = 1'b1; d_addr = 16'h0031; mem_rdata = 16'hFFFF;
    step(); smp();
`ifdef MEM_ARB_ALIGN_CHK_EN
    chk("al_c1_en", mem_en, 0); chk("al_c1_ddone", d_done, 1);
    chk("al_c1_err", err, 1); chk("al_c1_drdata", d_rdata, 16'h0000);
    step(); d_rd = 1'b0;
    smp(); chk("al_c2_err", err, 0); chk("al_c2_ddone", d_done, 0);
    step();
`else
    chk("al_c1_en", mem_en, 1); chk("al_c1_addr", mem_addr, 16'h0031); chk("al_c1_err", err, 0);
    step();
    step(); mem_rdy = 1'b1; mem_rdata = 16'h3131;
    smp(); chk("al_c3_ddone", d_done, 1); chk("al_c3_drdata", d_rdata, 16'h3131);
    step(); mem_rdy = 1'b0; d_rd = 1'b0;
    step();
`endif

    // read and write together act as a write
    d_rd = 1'b1; d_wr = 1'b1; d_addr = 16'h0080; d_wdata = 16'h5A5A;
    step(); smp();
    chk("rw_c1_en", mem_en, 1); chk("rw_c1_wr", mem_wr, 1); chk("rw_c1_wdata", mem_wdata, 16'h5A5A);
    step();
    step(); mem_rdy = 1'b1;
    smp(); chk("rw_c3_ddone", d_done, 1);
    step(); mem_rdy = 1'b0; d_rd = 1'b0; d_wr = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got=running expected=done");
    $fatal(1);
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates the single-ported unified memory between the instruction-fetch port (fetch stage) and the data port (memory stage) of the 5-stage 16-bit pipeline. It serialises transactions to a variable-latency memory and produces per-port done pulses and stall signals; the hazard/stall logic uses those signals to freeze the IF_ID and EX_MEM latches. The data port has priority, and a streak counter guarantees fetch progress.

## Interface
- MAX_D_STREAK, 4: consecutive data grants allowed while a fetch is pending before the fetch is forced through; legal range 1–15.
- clk  in  1  system clock; all state changes on the posedge.
- rst  in  1  synchronous, active-high reset.
- i_req  in  1  fetch read request; level, held until i_done.
- i_addr  in  16  fetch byte address.
- i_done  out  1  one-cycle pulse: i_rdata valid.
- i_rdata  out  16  fetched instruction.
- i_stall  out  1  i_req & ~i_done.
- d_rd, d_wr  in  1 each  data read / write request; level, held until d_done.
- d_addr, d_wdata  in  16 each  data address, store data.
- d_done  out  1  one-cycle pulse: read data valid or write committed.
- d_rdata  out  16  load data.
- d_stall  out  1  (d_rd|d_wr) & ~d_done.
- mem_en  out  1  one-cycle pulse: start a backend transaction.
- mem_wr  out  1  backend write enable, qualified by mem_en.
- mem_addr, mem_wdata  out  16 each  backend address and data, held from mem_en until mem_rdy.
- mem_rdy  in  1  backend completion pulse; mem_rdata valid in the same cycle.
- mem_rdata  in  16  backend read data.
- err  out  1  alignment-error pulse (see Configuration).

## Operation
- States: IDLE, I_BUSY, D_BUSY, ERR.
- IDLE: with no request, stay. With a request, choose a winner:
  - Data wins if d_rd|d_wr is high and NOT (i_req high and streak == MAX_D_STREAK).
  - Otherwise the fetch wins if i_req is high.
  - Move to the winner's BUSY state. mem_en is registered high for exactly the first BUSY cycle. mem_addr, mem_wr and mem_wdata are latched at the grant.
- d_rd and d_wr both high: treated as a write.
- BUSY: wait for mem_rdy. In the mem_rdy cycle:
  - Combinationally pulse the owner's done and pass mem_rdata through to the owner's rdata.
  - Next state is IDLE.
  - mem_rdy seen in IDLE or ERR is ignored.
- Streak counter, 4 bits:
  - On a data grant with i_req high: increment, saturating at MAX_D_STREAK.
  - On a data grant with i_req low: clear.
  - On a fetch grant: clear.
- Requester drops its request mid-transaction (flush): the transaction still completes and done still pulses; the requester ignores it. The backend is never aborted.
- rdata outputs are 0 whenever done is low.
- Reset state: IDLE, streak = 0.
- Reset values of outputs: mem_en, mem_wr, i_done, d_done and err are 0. mem_addr, mem_wdata, i_rdata and d_rdata are 16'h0000. Stalls follow their equations.
- Reset mid-transaction: return to IDLE; the backend shares rst and abandons the transaction.

## Timing
- Request sampled in cycle 0 (IDLE). mem_en is high in cycle 1. mem_rdy is legal from cycle 2 onward. done is in the same cycle as mem_rdy.
- Minimum transaction: 3 cycles.
- Every transaction returns through IDLE, so back-to-back grants are 3 cycles apart at minimum latency.
- Stalls are combinational from the requests and done; there is no extra cycle of stall after done.

## Configuration
- MEM_ARB_ALIGN_CHK_EN defined:
  - A granted request with addr[0] = 1 goes to ERR instead of BUSY; no mem_en is issued.
  - ERR lasts one cycle. It pulses the owner's done and err, with rdata = 0, then returns to IDLE.
  - A misaligned write is dropped.
  - The streak counter updates as for a normal grant.
- Undefined: err is tied 0, ERR is unreachable, and addresses pass through unchecked.

## Test plan
- Single fetch, backend latency 2: i_req with i_addr = 16'h0010 at cycle 0.
  - Required: mem_en at cycle 1 with mem_addr = 16'h0010, mem_wr = 0.
  - mem_rdy with mem_rdata = 16'hC001 at cycle 3 gives i_done = 1, i_rdata = 16'hC001 at cycle 3; i_stall is high in cycles 0–2.
- Simultaneous i_req and d_wr (d_addr = 16'h0020, d_wdata = 16'hBEEF):
  - Data is granted first: mem_wr = 1, mem_wdata = 16'hBEEF.
  - The fetch is granted in the IDLE cycle after d_done.
- Starvation guard, MAX_D_STREAK = 4: i_req and d_rd both held continuously.
  - Required grant order: D, D, D, D, I, D, D, D, D, I.
- Flush: i_req dropped in cycle 2 of an I_BUSY.
  - i_done still pulses on mem_rdy, and the FSM reaches IDLE the next cycle.
- Reset mid-transaction: rst in the cycle after mem_en.
  - The next cycle shows IDLE with all outputs at their reset values; a subsequent mem_rdy produces no done.
- With MEM_ARB_ALIGN_CHK_EN: d_rd with d_addr = 16'h0031.
  - Required: no mem_en; d_done = 1 and err = 1 in cycle 1, d_rdata = 0.
  - Without the macro, mem_en is issued with mem_addr = 16'h0031.
